crossbar_requester: RTL

Initiator-side port controller for one input of the 2x2 crossbar. It buffers commands from a local master in a small FIFO and raises `request` to the crossbar arbiter. After `grant` it drives one beat onto the crossbar data path, then pulses `acknowledge` to release the grant. One instance sits on each arbiter request/acknowledge bit pair.

---
 rtl/crossbar_requester.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/crossbar_requester.sv
// -----------------------------------------------------------------------------
// crossbar_requester
//
// Initiator-side port controller for one input of the 2x2 crossbar. Commands
// from the local master are buffered in a small FIFO. While the FIFO holds an
// entry the controller raises `request` to the arbiter. Once granted it drives
// exactly one beat (the FIFO head) onto the crossbar path. It then pulses
// `acknowledge` to release the grant, so `request` is low for at least one
// cycle between grants.
//
// Optional feature macro: GRANT_TIMEOUT_EN
//   When defined, the controller backs off to IDLE after GRANT_TIMEOUT
//   ungranted REQ cycles and pulses `timeout_err` for one cycle. When not
//   defined, REQ waits indefinitely and `timeout_err` is tied low.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   master command handshake (cmd_ready = FIFO not full)
//   cmd_addr/data/write   command payload
//   request/grant         arbiter request and grant bits
//   acknowledge           one-cycle grant release pulse after a completed beat
//   xbar_valid/ready      crossbar beat handshake
//   xbar_addr/data/write  FIFO head payload, shown only in XFER (zero otherwise)
//   timeout_err           one-cycle pulse when a grant wait times out
// -----------------------------------------------------------------------------
module crossbar_requester #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int GRANT_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_write,
    output logic                  request,
    input  logic                  grant,
    output logic                  acknowledge,
    output logic                  xbar_valid,
    output logic [ADDR_WIDTH-1:0] xbar_addr,
    output logic [DATA_WIDTH-1:0] xbar_data,
    output logic                  xbar_write,
    input  logic                  xbar_ready,
    output logic                  timeout_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("crossbar_requester: FIFO_DEPTH must be a power of two >= 2");
    end
    if (GRANT_TIMEOUT < 1) begin : g_bad_timeout
        $error("crossbar_requester: GRANT_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        ACK
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               timeout_hit;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // No bypass: a pop in the same cycle does not make room for a push.
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = xbar_valid && xbar_ready;
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset. Its contents are only observable
    // through a valid pointer/count, and the outputs are gated to zero outside
    // XFER, so clearing it would only add reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_addr, cmd_data, cmd_write};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(depth) bits, so they wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Optional grant-wait timeout
    // ---------------------------------------------------------------------
`ifdef GRANT_TIMEOUT_EN
    localparam int TO_W = $clog2(GRANT_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;

    // Fires in the REQ cycle whose missing grant brings the count to
    // GRANT_TIMEOUT, so the FSM sits in IDLE for exactly the next cycle.
    assign timeout_hit = (state_q == REQ) && !grant
                         && (wait_cnt == TO_W'(GRANT_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            // Held at zero outside REQ, so every REQ entry starts from zero.
            if (state_q == REQ && !grant && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement; a path that skipped an assignment would infer a latch.
    always_comb begin
        state_d     = state_q;
        request     = 1'b0;
        acknowledge = 1'b0;
        xbar_valid  = 1'b0;
        xbar_addr   = '0;
        xbar_data   = '0;
        xbar_write  = 1'b0;

        case (state_q)
            IDLE: begin
                // Looking at the incoming push lets `request` rise in the
                // cycle right after the command is accepted.
                if (!fifo_empty || push) state_d = REQ;
            end
            REQ: begin
                request = 1'b1;
                if (grant)            state_d = XFER;
                else if (timeout_hit) state_d = IDLE;
            end
            XFER: begin
                request = 1'b1;
                // Valid follows grant combinationally, so a withdrawn grant
                // takes the beat off the path in the same cycle.
                xbar_valid                          = grant;
                {xbar_addr, xbar_data, xbar_write}  = head;
                if (!grant)          state_d = REQ;
                else if (xbar_ready) state_d = ACK;
            end
            ACK: begin
                acknowledge = 1'b1;
                state_d     = fifo_empty ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
